turbo_result_collector: RTL
===========================

// Module: turbo_result_collector
// PURPOSE
//  Return-side companion to the Turbo dispatcher. The dispatcher splits pops across pipeline 0 and 1.
//  This block records the lane of every issued pop and buffers each lane's results in a per-lane FIFO.
//  It re-serialises results into pop-issue order on a valid/ready output with backpressure.
//  Sits between the two Turbo_Engine result ports and the PIFO pop consumer.
// PARAMETERS
//  DW     48  result word width (MTW+PTW); priority in [PTW-1:0]
//  PTW    16  priority field width
//  DEPTH  4   entries per FIFO (order FIFO and each lane FIFO); power of 2, >=2
//  CNTW   32  width of statistics counters (only used with TURBO_COLLECT_STATS_EN)
// PORTS
//  i_clk           in   1              clock
//  i_arst_n        in   1              asynchronous active-low reset
//  i_issue_valid   in   1              a pop was dispatched this cycle
//  i_issue_lane    in   1              lane of that pop (0/1)
//  o_issue_ready   out  1              order FIFO not full; dispatcher must hold pops when 0
//  i_p0_res_valid  in   1              pipeline-0 pop result strobe
//  i_p0_res_data   in   DW             pipeline-0 pop result
//  i_p1_res_valid  in   1              pipeline-1 pop result strobe
//  i_p1_res_data   in   DW             pipeline-1 pop result
//  o_pop_valid     out  1              registered output valid
//  o_pop_data      out  DW             registered output data, stable while valid && !ready
//  i_pop_ready     in   1              consumer accepts o_pop_data
//  o_pending       out  $clog2(DEPTH)+1  issued pops not yet loaded into output register
//  o_err           out  1              sticky: lane overflow or unsolicited result
// BEHAVIOUR
//  - Reset (async assert, sync release): all FIFOs empty, o_pop_valid=0, o_pop_data=0, o_pending=0,
//    o_err=0, o_issue_ready=1 after reset.
//  - Issue: i_issue_valid && o_issue_ready pushes i_issue_lane into the order FIFO.
//    i_issue_valid while !o_issue_ready is dropped and sets o_err.
//  - Result capture: each i_pN_res_valid writes into lane-N FIFO the same cycle.
//    A write while lane-N FIFO is full is dropped and sets o_err.
//    A write when lane N has zero outstanding issues (count in order FIFO) is an unsolicited result:
//    data is discarded and o_err is set.
//  - Output load: head = order FIFO head lane. Load occurs when lane[head] FIFO is non-empty and
//    (!o_pop_valid || i_pop_ready). On load: o_pop_data <= lane FIFO head, o_pop_valid <= 1,
//    pop both the order FIFO and lane[head] FIFO.
//  - No load and i_pop_ready: o_pop_valid <= 0.
//  - Latency: no bypass. A result written at cycle N is visible on o_pop_valid at N+2 at earliest.
//    Full throughput is 1 result/cycle when ready is held high.
//  - Ordering: results leave in issue order, even if the other lane's result arrives earlier.
//    A result that arrives early waits in its lane FIFO.
//  - Simultaneous events: issue push and output-load pop in one cycle leave the count unchanged.
//    Both lanes may deliver in the same cycle. A write to and read from the same lane FIFO in one
//    cycle is legal at any fill level except a write when full.
//  - Counters: occupancy counters are DEPTH-exact, with pointer wrap modulo DEPTH.
//    o_pending = order FIFO count.
//  - o_err stays set until reset. Reset mid-transfer discards all buffered data; no drain.
// CONFIGURATION
//  TURBO_COLLECT_STATS_EN defined: adds outputs o_stat_delivered[CNTW] and o_stat_err_cnt[CNTW].
//    o_stat_delivered counts accepted output handshakes.
//    o_stat_err_cnt counts o_err-causing events, one per cycle max.
//    Both counters saturate at all-ones and reset to 0.
//  Undefined: ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  turbo_pkg: localparam TURBO_DW, typedef logic [TURBO_DW-1:0] turbo_word_t, typedef logic turbo_lane_t.
//  Sub-module turbo_sync_fifo #(W,DEPTH): push/pop, full/empty/count, no bypass.
//    Three instances: order (W=1), lane0 (W=DW), lane1 (W=DW).
//  Top level holds per-lane outstanding counters, output register, error logic and stats.
// TESTING
//  1 Reset -> o_pop_valid=0, o_pending=0, o_err=0, o_issue_ready=1.
//  2 Issue lanes 0,1,0 (cycles 1-3).
//    Results: p1=0x..0005 @5, p0=0x..0009 @6, p0=0x..0003 @7, ready=1.
//    -> outputs in order 0009, 0005, 0003. First output valid at cycle 8. o_pending ends at 0.
//  3 Fill DEPTH=4 issues -> o_issue_ready=0, o_pending=4. 5th issue dropped and o_err=1.
//  4 Hold i_pop_ready=0 with 2 results buffered -> o_pop_data stable for 10 cycles.
//    Release -> back-to-back delivery, one per cycle.
//  5 p0 and p1 results in the same cycle for issues (1,0) -> lane-1 data output first, then lane-0.
//  6 p0 result with no outstanding lane-0 issue -> o_err=1, no output.
//    With TURBO_COLLECT_STATS_EN -> o_stat_err_cnt=1.
//    Assert reset mid-stream -> all outputs return to reset values.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the Turbo result-return path.
//   TURBO_DW      default result word width (MTW + PTW)
//   TURBO_PTW     default priority field width (priority sits in [PTW-1:0])
//   turbo_word_t  one result word
//   turbo_lane_t  pipeline lane identifier (0 or 1)
package turbo_pkg;

    localparam int unsigned TURBO_DW  = 48;
    localparam int unsigned TURBO_PTW = 16;

    typedef logic [TURBO_DW-1:0] turbo_word_t;
    typedef logic                turbo_lane_t;

endpackage

// File: rtl/turbo_sync_fifo.sv
// Synchronous FIFO with exact occupancy count, no write-to-read bypass.
// Parameters: W (word width), DEPTH (entries, power of 2, >= 2).
// Ports:
//   i_clk, i_arst_n  clock, asynchronous active-low reset
//   i_push, i_din    write request and data; ignored when full
//   i_pop            read request; ignored when empty
//   o_dout           head entry (valid while o_count != 0)
//   o_count          entries held, 0..DEPTH
module turbo_sync_fifo #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("turbo_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        wr_en    = i_push && (count_q != FULL_CNT);
        rd_en    = i_pop  && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = i_din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_dout  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/turbo_result_collector.sv
// Re-serialises Turbo pipeline pop results into pop-issue order.
// An order FIFO records the lane of every issued pop; each lane buffers its
// results in its own FIFO; the output register is loaded from the lane named
// by the order FIFO head, so an early result waits until its turn.
// Optional feature macro: TURBO_COLLECT_STATS_EN (adds o_stat_delivered and
// o_stat_err_cnt saturating counters).
// Ports:
//   i_clk, i_arst_n                 clock, asynchronous active-low reset
//   i_issue_valid, i_issue_lane     dispatched pop and its lane
//   o_issue_ready                   order FIFO has room
//   i_pN_res_valid, i_pN_res_data   pipeline N result strobe and word
//   o_pop_valid, o_pop_data         registered ordered output
//   i_pop_ready                     consumer accepts output
//   o_pending                       issued pops not yet loaded to output
//   o_err                           sticky error (dropped issue, lane overflow,
//                                   unsolicited result)
module turbo_result_collector
    import turbo_pkg::*;
#(
    parameter int unsigned DW    = TURBO_DW,
    parameter int unsigned PTW   = TURBO_PTW,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_issue_valid,
    input  logic                    i_issue_lane,
    output logic                    o_issue_ready,
    input  logic                    i_p0_res_valid,
    input  logic [DW-1:0]           i_p0_res_data,
    input  logic                    i_p1_res_valid,
    input  logic [DW-1:0]           i_p1_res_data,
    output logic                    o_pop_valid,
    output logic [DW-1:0]           o_pop_data,
    input  logic                    i_pop_ready,
    output logic [$clog2(DEPTH):0]  o_pending,
    output logic                    o_err
`ifdef TURBO_COLLECT_STATS_EN
    ,
    output logic [CNTW-1:0]         o_stat_delivered,
    output logic [CNTW-1:0]         o_stat_err_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (PTW == 0 || PTW > DW || CNTW == 0) begin : g_bad_cfg
        $error("turbo_result_collector: need 0 < PTW <= DW and CNTW > 0");
    end

    // Order FIFO
    logic          ord_push;
    logic          ord_pop;
    turbo_lane_t   head_lane;
    logic [CW-1:0] ord_cnt;

    // Lane FIFOs
    logic          l0_push, l1_push;
    logic          l0_pop,  l1_pop;
    logic [DW-1:0] l0_dout, l1_dout;
    logic [CW-1:0] l0_cnt,  l1_cnt;

    // Issues per lane still sitting in the order FIFO
    logic [CW-1:0] out0_q, out0_d;
    logic [CW-1:0] out1_q, out1_d;

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          err_q,   err_d;

    logic          load;
    logic          head_avail;
    logic          err_event;
    logic          p0_unsol, p1_unsol, p0_ovf, p1_ovf, issue_drop;

    turbo_sync_fifo #(.W(1), .DEPTH(DEPTH)) u_order (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_push   (ord_push),
        .i_din    (i_issue_lane),
        .i_pop    (ord_pop),
        .o_dout   (head_lane),
        .o_count  (ord_cnt)
    );

    turbo_sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_lane0 (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_push   (l0_push),
        .i_din    (i_p0_res_data),
        .i_pop    (l0_pop),
        .o_dout   (l0_dout),
        .o_count  (l0_cnt)
    );

    turbo_sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_lane1 (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_push   (l1_push),
        .i_din    (i_p1_res_data),
        .i_pop    (l1_pop),
        .o_dout   (l1_dout),
        .o_count  (l1_cnt)
    );

    always_comb begin
        o_issue_ready = (ord_cnt != FULL_CNT);
        ord_push      = i_issue_valid && o_issue_ready;
        issue_drop    = i_issue_valid && !o_issue_ready;

        // Unsolicited takes precedence: such data is discarded regardless of fill.
        p0_unsol = i_p0_res_valid && (out0_q == '0);
        p1_unsol = i_p1_res_valid && (out1_q == '0);
        p0_ovf   = i_p0_res_valid && !p0_unsol && (l0_cnt == FULL_CNT);
        p1_ovf   = i_p1_res_valid && !p1_unsol && (l1_cnt == FULL_CNT);
        l0_push  = i_p0_res_valid && !p0_unsol && !p0_ovf;
        l1_push  = i_p1_res_valid && !p1_unsol && !p1_ovf;

        head_avail = (ord_cnt != '0) &&
                     ((head_lane == 1'b0) ? (l0_cnt != '0) : (l1_cnt != '0));
        load       = head_avail && (!valid_q || i_pop_ready);
        ord_pop    = load;
        l0_pop     = load && (head_lane == 1'b0);
        l1_pop     = load && (head_lane == 1'b1);

        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = (head_lane == 1'b0) ? l0_dout : l1_dout;
        end else if (i_pop_ready) begin
            valid_d = 1'b0;
        end

        out0_d = out0_q;
        unique case ({ord_push && !i_issue_lane, l0_pop})
            2'b10:   out0_d = out0_q + 1'b1;
            2'b01:   out0_d = out0_q - 1'b1;
            default: out0_d = out0_q;
        endcase
        out1_d = out1_q;
        unique case ({ord_push && i_issue_lane, l1_pop})
            2'b10:   out1_d = out1_q + 1'b1;
            2'b01:   out1_d = out1_q - 1'b1;
            default: out1_d = out1_q;
        endcase

        err_event = issue_drop || p0_unsol || p1_unsol || p0_ovf || p1_ovf;
        err_d     = err_q || err_event;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
        end
    end

    assign o_pop_valid = valid_q;
    assign o_pop_data  = data_q;
    assign o_pending   = ord_cnt;
    assign o_err       = err_q;

`ifdef TURBO_COLLECT_STATS_EN
    logic [CNTW-1:0] deliv_q, deliv_d;
    logic [CNTW-1:0] errcnt_q, errcnt_d;

    always_comb begin
        deliv_d  = deliv_q;
        errcnt_d = errcnt_q;
        if (valid_q && i_pop_ready && (deliv_q != '1)) begin
            deliv_d = deliv_q + 1'b1;
        end
        if (err_event && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            deliv_q  <= '0;
            errcnt_q <= '0;
        end else begin
            deliv_q  <= deliv_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign o_stat_delivered = deliv_q;
    assign o_stat_err_cnt   = errcnt_q;
`endif

endmodule
